servo_pwm_decoder: RTL and testbench

- Receive-side counterpart to servo_driver: samples a 50 Hz servo PWM line (SERVO_H or SERVO_V, or the external servo feedback pin) and measures high time and period in CLK cycles.
- Converts the high time into an 8-bit position code and reports range errors and a missing-signal timeout.
- Sits on pll_clk next to the servo drivers, so the FSM and bench can close the loop on commanded servo position.

---
 rtl/servo_pwm_decoder.sv | 159 +++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures high time and rise-to-rise period of a
// 50 Hz servo line, scales the high time to an 8-bit position code and
// flags out-of-range pulses and missing-signal timeouts.
//
// Ports:
//   CLK         system clock (pll_clk)
//   RST         synchronous reset, active-high
//   SERVO_IN    asynchronous PWM line
//   PULSE_WIDTH last measured high time in cycles
//   PERIOD      last rise-to-rise interval in cycles
//   POSITION    scaled position code
//   VALID       one-cycle strobe when PULSE_WIDTH/POSITION/RANGE_ERR update
//   RANGE_ERR   last pulse outside [MIN_PULSE, MAX_PULSE]
//   TIMEOUT     sticky: no rise within PERIOD_TIMEOUT cycles
module servo_pwm_decoder #(
  parameter int unsigned MIN_PULSE      = 100000,
  parameter int unsigned MAX_PULSE      = 200000,
  parameter int unsigned PERIOD_TIMEOUT = 2500000,
  parameter int unsigned CNT_W          = 22,
  parameter int unsigned POS_SHIFT      = 9
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SERVO_IN,
  output logic [CNT_W-1:0] PULSE_WIDTH,
  output logic [CNT_W-1:0] PERIOD,
  output logic [7:0]       POSITION,
  output logic             VALID,
  output logic             RANGE_ERR,
  output logic             TIMEOUT
);

  localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] TO_W  = CNT_W'(PERIOD_TIMEOUT);
  localparam logic [CNT_W-1:0] SAT_W = CNT_W'(255);

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    HIGH
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [1:0]       rdy;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic             prev_rise;

  // measurement pipeline: fall -> scale -> publish
  logic             v0, v1;
  logic [CNT_W-1:0] w0, w1;
  logic [7:0]       pos1;
  logic             err1;

  logic             rise, fall;
  logic             below;
  logic [CNT_W-1:0] shifted;
  logic [7:0]       pos_c;
  logic             err_c;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_comb begin
    below   = w0 < MIN_W;
    shifted = (w0 - MIN_W) >> POS_SHIFT;
    pos_c   = 8'd0;
    if (!below)
      pos_c = (shifted > SAT_W) ? 8'hff : shifted[7:0];
    err_c   = below | (w0 > MAX_W);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= WAIT_LOW;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      rdy         <= 2'b00;
      per_cnt     <= '0;
      hi_cnt      <= '0;
      prev_rise   <= 1'b0;
      v0          <= 1'b0;
      v1          <= 1'b0;
      w0          <= '0;
      w1          <= '0;
      pos1        <= 8'd0;
      err1        <= 1'b0;
      PULSE_WIDTH <= '0;
      PERIOD      <= '0;
      POSITION    <= 8'd0;
      VALID       <= 1'b0;
      RANGE_ERR   <= 1'b0;
      TIMEOUT     <= 1'b0;
    end else begin
      s1    <= SERVO_IN;
      s2    <= s1;
      s3    <= s2;
      rdy   <= {rdy[0], 1'b1};
      v0    <= 1'b0;
      v1    <= v0;
      VALID <= v1;

      if (v0) begin
        w1   <= w0;
        pos1 <= pos_c;
        err1 <= err_c;
      end
      if (v1) begin
        PULSE_WIDTH <= w1;
        POSITION    <= pos1;
        RANGE_ERR   <= err1;
      end

      unique case (state)
        // rdy keeps the cleared synchronizer from faking a low
        // right after reset while the pin is still high
        WAIT_LOW: begin
          per_cnt <= '0;
          if (rdy[1] && !s2)
            state <= WAIT_RISE;
        end
        WAIT_RISE, HIGH: begin
          if (per_cnt >= TO_W) begin
            TIMEOUT   <= 1'b1;
            prev_rise <= 1'b0;
            per_cnt   <= '0;
            state     <= WAIT_LOW;
          end else if (state == WAIT_RISE) begin
            if (rise) begin
              state     <= HIGH;
              hi_cnt    <= CNT_W'(1);
              per_cnt   <= CNT_W'(1);
              prev_rise <= 1'b1;
              TIMEOUT   <= 1'b0;
              if (prev_rise)
                PERIOD <= per_cnt;
            end else begin
              per_cnt <= per_cnt + 1'b1;
            end
          end else begin
            per_cnt <= per_cnt + 1'b1;
            if (fall) begin
              state <= WAIT_RISE;
              w0    <= hi_cnt;
              v0    <= 1'b1;
            end else if (s2) begin
              hi_cnt <= hi_cnt + 1'b1;
            end
          end
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Self-checking bench for servo_pwm_decoder with scaled-down timing.
// Table of pulses plus hand sequences for timeout and reset cases.
module tb_servo_pwm_decoder;

  localparam int MIN_P = 200;
  localparam int MAX_P = 400;
  localparam int TO    = 3000;
  localparam int CW    = 12;
  localparam int SH    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          servo;
  logic [CW-1:0] pulse_width;
  logic [CW-1:0] period;
  logic [7:0]    position;
  logic          valid;
  logic          range_err;
  logic          timeout;

  servo_pwm_decoder #(
    .MIN_PULSE      (MIN_P),
    .MAX_PULSE      (MAX_P),
    .PERIOD_TIMEOUT (TO),
    .CNT_W          (CW),
    .POS_SHIFT      (SH)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .SERVO_IN    (servo),
    .PULSE_WIDTH (pulse_width),
    .PERIOD      (period),
    .POSITION    (position),
    .VALID       (valid),
    .RANGE_ERR   (range_err),
    .TIMEOUT     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int l;
    int w;
    int pos;
    int err;
  } vec_t;

  typedef struct {
    int w;
    int pos;
    int err;
    int at;
  } exp_t;

  vec_t tbl[12];
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int per_exp;
  int t_rise;
  bit armed = 0;
  int h_pw  = 0;
  int h_pos = 0;
  int h_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", int'(valid), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_width", int'(pulse_width), e.w);
          chk("position", int'(position), e.pos);
          chk("range_err", int'(range_err), e.err);
          chk("valid_cycle", cyc, e.at);
          h_pw  = e.w;
          h_pos = e.pos;
          h_err = e.err;
        end
      end else begin
        chk("hold", {pulse_width, position, range_err},
            {h_pw[CW-1:0], h_pos[7:0], h_err[0]});
      end
    end
  end

  // Entered and left at #1 after a posedge.
  task automatic pulse(input int h, input int l,
                       input int ew, input int ep, input int ee);
    exp_t e;
    servo  = 1'b1;
    t_rise = cyc;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("period", int'(period), per_exp);
    chk("timeout_clr", int'(timeout), 0);
    per_exp = h + l;
    repeat (h - 4) @(posedge clk);
    #1;
    servo = 1'b0;
    e.w   = ew;
    e.pos = ep;
    e.err = ee;
    e.at  = cyc + 5;
    q.push_back(e);
    repeat (l) @(posedge clk);
    #1;
    if (l > 8)
      chk("drained", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int save;
    bit seen;
    int t_exp;

    tbl[0]  = '{300, 1700, 300,  50, 0};
    tbl[1]  = '{300, 1700, 300,  50, 0};
    tbl[2]  = '{300, 1700, 300,  50, 0};
    tbl[3]  = '{200, 1800, 200,   0, 0};
    tbl[4]  = '{400, 1600, 400, 100, 0};
    tbl[5]  = '{199, 1801, 199,   0, 1};
    tbl[6]  = '{401, 1599, 401, 100, 1};
    tbl[7]  = '{180, 1820, 180,   0, 1};
    tbl[8]  = '{301, 1699, 301,  50, 0};
    tbl[9]  = '{711, 1289, 711, 255, 1};
    tbl[10] = '{713, 1287, 713, 255, 1};
    tbl[11] = '{800, 1200, 800, 255, 1};

    rst   = 1'b1;
    servo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    chk("reset_outputs",
        {pulse_width, period, position, valid, range_err, timeout}, 0);
    repeat (10) @(posedge clk);
    #1;
    per_exp = 0;

    for (int i = 0; i < 12; i++)
      pulse(tbl[i].h, tbl[i].l, tbl[i].w, tbl[i].pos, tbl[i].err);

    // held low after a pulse -> timeout, sticky, cleared by next rise
    save = per_exp;
    pulse(300, 100, 300, 50, 0);
    t_exp = t_rise + TO + 3;
    seen  = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      seen = timeout;
    end
    chk("timeout_seen", int'(seen), 1);
    chk("timeout_cycle", cyc, t_exp);
    repeat (500) @(posedge clk);
    @(negedge clk);
    chk("timeout_sticky", int'(timeout), 1);
    @(posedge clk);
    #1;
    per_exp = save;
    pulse(300, 1500, 300, 50, 0);

    // stuck high: timeout, no VALID, then a clean pulse decodes
    servo = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stuck_period", int'(period), per_exp);
    save = per_exp;
    repeat (3196) @(posedge clk);
    @(negedge clk);
    chk("stuck_timeout", int'(timeout), 1);
    @(posedge clk);
    #1;
    servo = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    per_exp = save;
    pulse(300, 1700, 300, 50, 0);

    // reset in the middle of a pulse
    servo = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    h_pw    = 0;
    h_pos   = 0;
    h_err   = 0;
    per_exp = 0;
    @(negedge clk);
    chk("midreset_outputs",
        {pulse_width, period, position, valid, range_err, timeout}, 0);
    repeat (150) @(posedge clk);
    #1;
    servo = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    pulse(300, 1700, 300, 50, 0);

    repeat (20) @(posedge clk);
    chk("final_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
